// File: rtl/fsm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsm_seq_ctrl                                                 |
// | Description : Stimulus sequencer for a 4-state one-hot control FSM. Drives |
// |               a_out high/low/high/low with programmable dwell lengths and  |
// |               repeat count, with start/busy/done/abort handshake.          |
// |               Optional illegal-state detection: define SEQ_ERR_CHK_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fsm_seq_ctrl #(
  parameter int CNT_W  = 8,
  parameter int LOOP_W = 4
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_hi_len,
  input  logic [CNT_W-1:0]  cfg_lo_len,
  input  logic [LOOP_W-1:0] cfg_loops,
  output logic              a_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [4:0]        phase,
  output logic              err
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_HI1  = 5'b00010,
    S_LO1  = 5'b00100,
    S_HI2  = 5'b01000,
    S_LO2  = 5'b10000
  } state_t;

  // Bit positions of each state inside the one-hot vector
  localparam int c_IDLE_B = 0;
  localparam int c_HI1_B  = 1;
  localparam int c_LO1_B  = 2;
  localparam int c_HI2_B  = 3;
  localparam int c_LO2_B  = 4;

  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] c_LOOP_ONE = {{(LOOP_W-1){1'b0}}, 1'b1};

  // Kept as a plain vector so an illegal (non one-hot) value is representable
  logic [4:0]        r_state, w_state_nx;
  logic [CNT_W-1:0]  r_dwell, w_dwell_nx;
  logic [LOOP_W-1:0] r_loop,  w_loop_nx;
  logic [CNT_W-1:0]  r_hi,    w_hi_nx;
  logic [CNT_W-1:0]  r_lo,    w_lo_nx;
  logic              r_a,     w_a_nx;
  logic              r_busy,  w_busy_nx;
  logic              r_done,  w_done_nx;
  logic              r_abrt,  w_abrt_nx;
  logic              r_err,   w_err_nx;

  logic [CNT_W-1:0]  w_hi_eff;
  logic [CNT_W-1:0]  w_lo_eff;
  logic [LOOP_W-1:0] w_loops_eff;
  logic              w_running;
  logic              w_onehot;

  // Zero-length config is promoted to one so every phase lasts at least a cycle
  assign w_hi_eff    = (cfg_hi_len == '0) ? c_CNT_ONE  : cfg_hi_len;
  assign w_lo_eff    = (cfg_lo_len == '0) ? c_CNT_ONE  : cfg_lo_len;
  assign w_loops_eff = (cfg_loops  == '0) ? c_LOOP_ONE : cfg_loops;
  assign w_running   = |r_state[4:1];
  assign w_onehot    = (r_state != 5'b00000) && ((r_state & (r_state - 5'd1)) == 5'b00000);

  // Next-state, counter and output computation
  always_comb begin
    w_state_nx = r_state;
    w_dwell_nx = r_dwell;
    w_loop_nx  = r_loop;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_a_nx     = r_a;
    w_done_nx  = 1'b0;
    w_abrt_nx  = 1'b0;
    w_err_nx   = r_err;
`ifdef SEQ_ERR_CHK_EN
    if (!w_onehot) begin
      w_state_nx = S_IDLE;
      w_dwell_nx = '0;
      w_loop_nx  = '0;
      w_a_nx     = 1'b0;
      w_err_nx   = 1'b1;
    end else
`endif
    if (abort && w_running) begin
      w_state_nx = S_IDLE;
      w_dwell_nx = '0;
      w_loop_nx  = '0;
      w_a_nx     = 1'b0;
      w_abrt_nx  = 1'b1;
    end else begin
      case (1'b1)
        r_state[c_IDLE_B]: begin
          if (start && !abort) begin
            w_hi_nx    = w_hi_eff;
            w_lo_nx    = w_lo_eff;
            w_dwell_nx = w_hi_eff - c_CNT_ONE;
            w_loop_nx  = w_loops_eff - c_LOOP_ONE;
            w_state_nx = S_HI1;
            w_a_nx     = 1'b1;
          end
        end
        r_state[c_HI1_B]: begin
          if (r_dwell == '0) begin
            w_state_nx = S_LO1;
            w_dwell_nx = r_lo - c_CNT_ONE;
            w_a_nx     = 1'b0;
          end else begin
            w_dwell_nx = r_dwell - c_CNT_ONE;
          end
        end
        r_state[c_LO1_B]: begin
          if (r_dwell == '0) begin
            w_state_nx = S_HI2;
            w_dwell_nx = r_hi - c_CNT_ONE;
            w_a_nx     = 1'b1;
          end else begin
            w_dwell_nx = r_dwell - c_CNT_ONE;
          end
        end
        r_state[c_HI2_B]: begin
          if (r_dwell == '0) begin
            w_state_nx = S_LO2;
            w_dwell_nx = r_lo - c_CNT_ONE;
            w_a_nx     = 1'b0;
          end else begin
            w_dwell_nx = r_dwell - c_CNT_ONE;
          end
        end
        r_state[c_LO2_B]: begin
          if (r_dwell != '0) begin
            w_dwell_nx = r_dwell - c_CNT_ONE;
          end else if (r_loop != '0) begin
            w_loop_nx  = r_loop - c_LOOP_ONE;
            w_state_nx = S_HI1;
            w_dwell_nx = r_hi - c_CNT_ONE;
            w_a_nx     = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_a_nx     = 1'b0;
            w_done_nx  = 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_dwell_nx = '0;
          w_loop_nx  = '0;
          w_a_nx     = 1'b0;
        end
      endcase
    end
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dwell <= '0;
      r_loop  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abrt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dwell <= w_dwell_nx;
      r_loop  <= w_loop_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_a     <= w_a_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_abrt  <= w_abrt_nx;
      r_err   <= w_err_nx;
    end
  end

  assign a_out   = r_a;
  assign busy    = r_busy;
  assign done    = r_done;
  assign aborted = r_abrt;
  assign phase   = r_state;
`ifdef SEQ_ERR_CHK_EN
  assign err     = r_err;
`else
  // Without the checker the flag is constant; the register is optimised away
  assign err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fsm_seq_ctrl                                              |
// | Description : Directed self-checking bench for fsm_seq_ctrl.               |
// |               Illegal-state scenario is built only with SEQ_ERR_CHK_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fsm_seq_ctrl;

  logic       sclk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_hi_len;
  logic [7:0] cfg_lo_len;
  logic [3:0] cfg_loops;
  logic       a_out;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [4:0] phase;
  logic       err;

  int r_checks;
  int r_fails;

  fsm_seq_ctrl #(.CNT_W(8), .LOOP_W(4)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_hi_len (cfg_hi_len),
    .cfg_lo_len (cfg_lo_len),
    .cfg_loops  (cfg_loops),
    .a_out      (a_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .phase      (phase),
    .err        (err)
  );

  // Free-running clock
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'h01);
    chk({tag, "_a"},     32'(a_out), 32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h0);
    chk({tag, "_done"},  32'(done),  32'h0);
    chk({tag, "_abrt"},  32'(aborted), 32'h0);
  endtask

  // Run one sequence from the current cycle (cycle 0) and compare per-cycle
  // a_out/busy/done against bit c of the hand-computed expectation masks.
  // mess=1 scrambles cfg at cycle 3 and pulses start at cycle 5.
  task automatic run_seq(input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] loops,
                         input int ncyc, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ed, input bit mess, input string tag);
    cfg_hi_len = hi;
    cfg_lo_len = lo;
    cfg_loops  = loops;
    start      = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      start = (mess && c == 5);
      if (mess && c == 3) begin
        cfg_hi_len = 8'd7;
        cfg_lo_len = 8'd9;
        cfg_loops  = 4'd5;
      end
      chk($sformatf("%s_a_c%0d", tag, c),    32'(a_out),   32'(ea[c]));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy),    32'(eb[c]));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done),    32'(ed[c]));
      chk($sformatf("%s_abrt_c%0d", tag, c), 32'(aborted), 32'h0);
    end
    start = 1'b0;
  endtask

  initial begin
    r_checks   = 0;
    r_fails    = 0;
    rst_n      = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    cfg_hi_len = 8'd3;
    cfg_lo_len = 8'd2;
    cfg_loops  = 4'd1;

    // Reset held with start asserted
    repeat (3) tick();
    chk_idle("rst");
    chk("rst_err", 32'(err), 32'h0);
    #2 rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk_idle("post_rst");

    // Basic run hi=3 lo=2 loops=1
    run_seq(8'd3, 8'd2, 4'd1, 11, 32'h0000_01CE, 32'h0000_07FE, 32'h0000_0800, 1'b0, "basic");
    tick();
    chk_idle("basic_after");

    // Zero config -> 1/1/1
    run_seq(8'd0, 8'd0, 4'd0, 5, 32'h0000_000A, 32'h0000_001E, 32'h0000_0020, 1'b0, "zero");
    tick();
    chk_idle("zero_after");

    // Three loops hi=2 lo=1 with cfg changes and a stray start mid-run
    run_seq(8'd2, 8'd1, 4'd3, 19, 32'h0003_6DB6, 32'h0007_FFFE, 32'h0008_0000, 1'b1, "loop3");
    tick();
    chk_idle("loop3_after");

    // Abort at cycle 4 of the basic run
    cfg_hi_len = 8'd3;
    cfg_lo_len = 8'd2;
    cfg_loops  = 4'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abrt_c4_a",     32'(a_out), 32'h0);
    chk("abrt_c4_phase", 32'(phase), 32'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abrt_c5_a",     32'(a_out),   32'h0);
    chk("abrt_c5_phase", 32'(phase),   32'h01);
    chk("abrt_c5_busy",  32'(busy),    32'h0);
    chk("abrt_c5_pulse", 32'(aborted), 32'h1);
    chk("abrt_c5_done",  32'(done),    32'h0);
    for (int c = 6; c <= 12; c++) begin
      tick();
      chk($sformatf("abrt_c%0d", c), 32'({done, aborted, busy}), 32'h0);
    end

    // Abort together with start in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_idle("abrt_idle");
    tick();
    chk_idle("abrt_idle2");

    // Back-to-back: start held through the done cycle, hi=lo=loops=1
    cfg_hi_len = 8'd1;
    cfg_lo_len = 8'd1;
    cfg_loops  = 4'd1;
    start      = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'h1);
    end
    tick();
    chk("b2b_c5_done",  32'(done),  32'h1);
    chk("b2b_c5_phase", 32'(phase), 32'h01);
    tick();
    start = 1'b0;
    chk("b2b_c6_a",     32'(a_out), 32'h1);
    chk("b2b_c6_phase", 32'(phase), 32'h02);
    chk("b2b_c6_done",  32'(done),  32'h0);
    repeat (3) tick();
    tick();
    chk("b2b_c10_done", 32'(done), 32'h1);
    tick();
    chk_idle("b2b_after");

    // Asynchronous reset at cycle 5 of the basic run
    cfg_hi_len = 8'd3;
    cfg_lo_len = 8'd2;
    cfg_loops  = 4'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mrst_c5_busy", 32'(busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("mrst");
    tick();
    chk_idle("mrst_held");
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk_idle("mrst_rel");
    chk("mrst_err", 32'(err), 32'h0);

`ifdef SEQ_ERR_CHK_EN
    // Illegal state injection
    cfg_hi_len = 8'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    force dut.r_state = 5'b00110;
    #1;
    chk("err_forced", 32'(phase), 32'h06);
    release dut.r_state;
    tick();
    chk("err_phase", 32'(phase),   32'h01);
    chk("err_a",     32'(a_out),   32'h0);
    chk("err_flag",  32'(err),     32'h1);
    chk("err_pulse", 32'({done, aborted}), 32'h0);
    repeat (5) tick();
    chk("err_sticky", 32'(err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("err_rst", 32'(err), 32'h0);
    #2 rst_n = 1'b1;
    tick();
`else
    chk("err_tied", 32'(err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
Sequencer that generates the single-bit control stimulus `a_out` for the 4-state one-hot control FSM. It drives `a_out` through the high/low/high/low pattern that moves that FSM through IDLE→START→STOP→CLEAR→IDLE. Dwell lengths and repeat count are programmable, with a start/busy/done handshake and abort. It sits between the host/test logic and the FSM's `A` input.

Parameters:
CNT_W, 8, width of dwell-length inputs and internal dwell counter
LOOP_W, 4, width of repeat-count input and internal loop counter

Ports:
sclk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to run a sequence; sampled only in IDLE
abort  input  1  terminate the sequence; wins over everything
cfg_hi_len  input  CNT_W  cycles `a_out` is held high per high phase (0 treated as 1)
cfg_lo_len  input  CNT_W  cycles `a_out` is held low per low phase (0 treated as 1)
cfg_loops  input  LOOP_W  number of full HI1-LO1-HI2-LO2 passes (0 treated as 1)
a_out  output  1  registered stimulus to the controlled FSM's `A` input
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when all passes complete normally
aborted  output  1  one-cycle pulse when a running sequence is aborted
phase  output  5  current one-hot state
err  output  1  sticky illegal-state flag (see Optional Feature)

Behaviour:
- Reset values: state=IDLE (5'b00001), `a_out`=0, `busy`=0, `done`=0, `aborted`=0, `err`=0, counters=0, latched config=0.
- States are one-hot: IDLE=00001, HI1=00010, LO1=00100, HI2=01000, LO2=10000. `phase` = state register.
- All outputs are registered; none is combinational from inputs.
- Decoding uses single-bit tests of the one-hot state.
- IDLE, start=1, abort=0:
  - latch cfg_hi_len, cfg_lo_len and cfg_loops, applying the 0→1 substitution;
  - load the dwell counter with hi-1 and the loop counter with loops-1;
  - next state HI1.
  - `a_out`=1 and `busy`=1 from the next cycle.
- Config inputs are ignored after the latch; changes during a run have no effect.
- start while busy is ignored; no queuing.
- Dwell rule: in each active state the dwell counter decrements every cycle. When it reads 0, move to the next state and reload the counter:
  - HI1→LO1 (load lo-1, `a_out`=0)
  - LO1→HI2 (load hi-1, `a_out`=1)
  - HI2→LO2 (load lo-1, `a_out`=0)
- LO2 with dwell=0:
  - if loop counter ≠ 0: decrement it, go to HI1, load hi-1, `a_out`=1;
  - else: go to IDLE, `a_out`=0, pulse `done` for 1 cycle.
- Each high phase therefore lasts exactly hi cycles and each low phase exactly lo cycles. One pass totals 2*(hi+lo) cycles.
- `done` is high in the first IDLE cycle. A start sampled in that same cycle is accepted.
- abort=1 in any non-IDLE state:
  - next cycle state=IDLE, `a_out`=0, `busy`=0, `aborted` pulses 1 cycle, `done` stays 0;
  - counters cleared.
- abort in IDLE: no effect, no pulse, and any simultaneous start is dropped.
- abort in the final LO2 cycle: `aborted` pulses and `done` does not.
- Counter arithmetic is unsigned. Maximum run is hi=lo=2^CNT_W-1 with loops=2^LOOP_W-1; no overflow is possible because counters only load and decrement.
- Reset asserted mid-sequence returns everything to reset values asynchronously. No `done` or `aborted` pulse is generated.

Optional Feature:
Macro SEQ_ERR_CHK_EN.
- Defined: in any cycle where `phase` is not exactly one-hot (zero or multiple bits set):
  - force state to IDLE and `a_out` to 0 on the next edge;
  - set `err`, which stays sticky until rst_n;
  - no `done`/`aborted` pulse.
- Not defined: the case default silently returns to IDLE, and `err` is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with start=1 → `phase`=00001 and `a_out`, `busy`, `done`, `aborted`, `err` all 0; assert mid-run at cycle 5 → immediate return to these values.
- Basic run, hi=3, lo=2, loops=1, start pulse at cycle 0:
  - `a_out`=1 cycles 1-3, 0 cycles 4-5, 1 cycles 6-8, 0 cycles 9-10;
  - `done`=1 at cycle 11, `busy` 1 for cycles 1-10.
- Zero config, hi=0, lo=0, loops=0 → treated as 1/1/1: `a_out` pattern 1,0,1,0 over cycles 1-4, `done` at cycle 5.
- Loops=3, hi=2, lo=1:
  - 18 busy cycles with the pattern repeated 3 times and a single `done` at cycle 19;
  - cfg changed mid-run has no effect;
  - start at cycle 5 is ignored.
- Abort:
  - abort at cycle 4 of the basic run → cycle 5 `a_out`=0, `phase`=00001, `aborted`=1, `done` never asserts;
  - abort+start together in IDLE → stays IDLE.
- Back-to-back: start held high through the `done` cycle → a new sequence begins, with `a_out`=1 the cycle after `done`.
- With SEQ_ERR_CHK_EN: force `phase` to 00110 → next cycle IDLE and `err`=1, held until reset.
